// File: rtl/bot_feedback_reader.sv
// Three-slot bot feedback mailbox drained round-robin onto one report stream.
// Optional per-bot stale detection is compiled in with BOT_STALE_TIMEOUT_EN.
module bot_feedback_reader #(
   parameter int W           = 16,
   parameter int FRAC        = 11,
   parameter int TIMEOUT_CYC = 1000
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [2:0]     bot_valid,
   input  logic [3*W-1:0] px_bin,
   input  logic [3*W-1:0] py_bin,
   output logic [2:0]     bot_rdy,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [1:0]     out_id,
   output logic [W-1:0]   out_px,
   output logic [W-1:0]   out_py,
   output logic           frame_done,
   output logic [2:0]     stale
);

   // Handshakes (bot side and report side): a word moves on a rising edge where
   // valid and ready are both high; raised valid holds its data until that edge.

   if (FRAC > W) begin : g_frac_range
      $error("FRAC must not exceed W");
   end
   if (TIMEOUT_CYC < 1) begin : g_timeout_range
      $error("TIMEOUT_CYC must be at least 1");
   end

   typedef enum logic {
      ST_IDLE    = 1'b0,
      ST_PRESENT = 1'b1
   } out_state_t;

   out_state_t   state;
   out_state_t   state_nxt;

   logic [2:0]   slot_full;
   logic [W-1:0] slot_px [3];
   logic [W-1:0] slot_py [3];
   logic [2:0]   accept;

   logic [1:0]   last_id;
   logic [2:0]   seen;
   logic [2:0]   id_onehot;

   logic [1:0]   cand1;
   logic [1:0]   cand2;
   logic [1:0]   cand3;
   logic         grant_any;
   logic [1:0]   grant_id;
   logic         load;
   logic         xfer;

   function automatic logic [1:0] next_id(input logic [1:0] id);
      return (id == 2'd2) ? 2'd0 : id + 2'd1;
   endfunction

   assign accept  = bot_valid & ~slot_full;
   assign bot_rdy = ~slot_full;

   // Search starts just after the last served bot, so a busy bot cannot starve the others.
   always_comb begin
      cand1     = next_id(last_id);
      cand2     = next_id(cand1);
      cand3     = next_id(cand2);
      grant_any = 1'b1;
      grant_id  = 2'd0;
      if (slot_full[cand1]) begin
         grant_id = cand1;
      end else if (slot_full[cand2]) begin
         grant_id = cand2;
      end else if (slot_full[cand3]) begin
         grant_id = cand3;
      end else begin
         grant_any = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:    if (grant_any) state_nxt = ST_PRESENT;
         ST_PRESENT: if (out_ready) state_nxt = ST_IDLE;
         default:    state_nxt = ST_IDLE;
      endcase
   end

   // IDLE always lasts at least one cycle after a transfer, giving the bubble.
   always_comb begin
      out_valid = (state == ST_PRESENT);
      load      = (state == ST_IDLE) && grant_any;
      xfer      = (state == ST_PRESENT) && out_ready;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot_full <= '0;
         for (int i = 0; i < 3; i++) begin
            slot_px[i] <= '0;
            slot_py[i] <= '0;
         end
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (xfer && (out_id == i[1:0])) begin
               slot_full[i] <= 1'b0;
            end else if (accept[i]) begin
               slot_full[i] <= 1'b1;
               slot_px[i]   <= px_bin[i*W +: W];
               slot_py[i]   <= py_bin[i*W +: W];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_id <= 2'd0;
         out_px <= '0;
         out_py <= '0;
      end else if (load) begin
         out_id <= grant_id;
         out_px <= slot_px[grant_id];
         out_py <= slot_py[grant_id];
      end
   end

   assign id_onehot = 3'b001 << out_id;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_id    <= 2'd2;
         seen       <= '0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         if (xfer) begin
            last_id <= out_id;
            if ((seen | id_onehot) == 3'b111) begin
               seen       <= '0;
               frame_done <= 1'b1;
            end else begin
               seen <= seen | id_onehot;
            end
         end
      end
   end

`ifdef BOT_STALE_TIMEOUT_EN
   localparam int            CW      = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYC);

   logic [CW-1:0] stale_cnt [3];

   // Counts cycles since the bot was last accepted, parking at the limit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 3; i++) begin
            stale_cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (accept[i]) begin
               stale_cnt[i] <= '0;
            end else if (stale_cnt[i] != CNT_MAX) begin
               stale_cnt[i] <= stale_cnt[i] + 1'b1;
            end
         end
      end
   end

   always_comb begin
      for (int i = 0; i < 3; i++) begin
         stale[i] = (stale_cnt[i] == CNT_MAX);
      end
   end
`else
   assign stale = 3'b000;
`endif

endmodule

// File: tb/tb_bot_feedback_reader.sv
// Bench for bot_feedback_reader: per-cycle reference model plus directed scenarios
// with hand-derived expectations on the transfer and frame logs.
module tb_bot_feedback_reader;
   localparam int W  = 16;
   localparam int TO = 20;

   logic           clk;
   logic           rst_n;
   logic [2:0]     bot_valid = '0;
   logic [3*W-1:0] px_bin = '0;
   logic [3*W-1:0] py_bin = '0;
   logic [2:0]     bot_rdy;
   logic           out_valid;
   logic           out_ready;
   logic [1:0]     out_id;
   logic [W-1:0]   out_px;
   logic [W-1:0]   out_py;
   logic           frame_done;
   logic [2:0]     stale;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   bot_feedback_reader #(.W(W), .FRAC(11), .TIMEOUT_CYC(TO)) dut (
      .clk(clk), .rst_n(rst_n), .bot_valid(bot_valid), .px_bin(px_bin), .py_bin(py_bin),
      .bot_rdy(bot_rdy), .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id),
      .out_px(out_px), .out_py(out_py), .frame_done(frame_done), .stale(stale)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: mailbox contents, report register, frame membership.
   logic [2:0]   m_full;
   logic [2:0]   pre_full;
   logic [W-1:0] m_px [3];
   logic [W-1:0] m_py [3];
   logic         m_valid;
   logic         m_fd;
   int           m_id;
   int           m_last;
   int           mc;
   logic [W-1:0] m_opx;
   logic [W-1:0] m_opy;
   bit           m_seen [3];
   int           m_cnt [3];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_full = '0; m_valid = 1'b0; m_id = 0; m_opx = '0; m_opy = '0;
         m_last = 2; m_fd = 1'b0;
         for (int i = 0; i < 3; i++) begin
            m_seen[i] = 1'b0; m_cnt[i] = 0; m_px[i] = '0; m_py[i] = '0;
         end
      end else begin
         pre_full = m_full;
         m_fd = 1'b0;
         if (m_valid && out_ready) begin
            m_full[m_id] = 1'b0;
            m_last = m_id;
            m_seen[m_id] = 1'b1;
            m_valid = 1'b0;
            if (m_seen[0] && m_seen[1] && m_seen[2]) begin
               m_fd = 1'b1;
               for (int i = 0; i < 3; i++) m_seen[i] = 1'b0;
            end
         end else if (!m_valid) begin
            for (int k = 1; k <= 3; k++) begin
               mc = (m_last + k) % 3;
               if (pre_full[mc] && !m_valid) begin
                  m_valid = 1'b1; m_id = mc; m_opx = m_px[mc]; m_opy = m_py[mc];
               end
            end
         end
         for (int i = 0; i < 3; i++) begin
            if (bot_valid[i] && !pre_full[i]) begin
               m_full[i] = 1'b1;
               m_px[i] = px_bin[i*W +: W];
               m_py[i] = py_bin[i*W +: W];
               m_cnt[i] = 0;
            end else if (m_cnt[i] < TO) begin
               m_cnt[i]++;
            end
         end
      end
   end

   // Compare process plus transfer / frame logs for the directed checks.
   int         log_id [$];
   int         log_px [$];
   int         log_py [$];
   int         log_cyc [$];
   int         fd_cyc [$];
   logic [2:0] exp_rdy;
   logic [2:0] exp_st;

   always @(negedge clk) begin
      if (!rst_n) begin
         chk("reset bot_rdy", int'(bot_rdy), 7);
         chk("reset out_valid", int'(out_valid), 0);
         chk("reset out_id", int'(out_id), 0);
         chk("reset out_px", int'(out_px), 0);
         chk("reset out_py", int'(out_py), 0);
         chk("reset frame_done", int'(frame_done), 0);
         chk("reset stale", int'(stale), 0);
      end else begin
         exp_rdy = ~m_full;
`ifdef BOT_STALE_TIMEOUT_EN
         for (int i = 0; i < 3; i++) exp_st[i] = (m_cnt[i] == TO);
`else
         exp_st = 3'b000;
`endif
         chk("model bot_rdy", int'(bot_rdy), int'(exp_rdy));
         chk("model out_valid", int'(out_valid), int'(m_valid));
         if (m_valid) begin
            chk("model out_id", int'(out_id), m_id);
            chk("model out_px", int'(out_px), int'(m_opx));
            chk("model out_py", int'(out_py), int'(m_opy));
         end
         chk("model frame_done", int'(frame_done), int'(m_fd));
         chk("model stale", int'(stale), int'(exp_st));
         if (out_valid && out_ready) begin
            log_id.push_back(int'(out_id));
            log_px.push_back(int'(out_px));
            log_py.push_back(int'(out_py));
            log_cyc.push_back(cyc + 1);
         end
         if (frame_done) fd_cyc.push_back(cyc);
      end
   end

   // Bot drivers: each bot holds its head word until it sees it accepted.
   logic [2*W-1:0] q0 [$];
   logic [2*W-1:0] q1 [$];
   logic [2*W-1:0] q2 [$];
   logic [2:0]     drv_rdy = '0;
   int             acc_cyc [3];

   function automatic int qsize(input int i);
      case (i)
         0:       return q0.size();
         1:       return q1.size();
         default: return q2.size();
      endcase
   endfunction

   function automatic logic [2*W-1:0] qfront(input int i);
      case (i)
         0:       return q0[0];
         1:       return q1[0];
         default: return q2[0];
      endcase
   endfunction

   task automatic qpop(input int i);
      case (i)
         0:       void'(q0.pop_front());
         1:       void'(q1.pop_front());
         default: void'(q2.pop_front());
      endcase
   endtask

   always @(negedge clk) drv_rdy = bot_rdy;

   always @(posedge clk) begin
      #2;
      if (!rst_n) begin
         bot_valid = '0;
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (bot_valid[i] && drv_rdy[i] && qsize(i) > 0) begin
               qpop(i);
               acc_cyc[i] = cyc;
            end
            if (qsize(i) > 0) begin
               bot_valid[i]     = 1'b1;
               px_bin[i*W +: W] = qfront(i) >> W;
               py_bin[i*W +: W] = qfront(i) & {{W{1'b0}}, {W{1'b1}}};
            end else begin
               bot_valid[i] = 1'b0;
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(input int i, input logic [W-1:0] x, input logic [W-1:0] y);
      case (i)
         0:       q0.push_back({x, y});
         1:       q1.push_back({x, y});
         default: q2.push_back({x, y});
      endcase
   endtask

   task automatic clear_logs();
      log_id.delete(); log_px.delete(); log_py.delete(); log_cyc.delete(); fd_cyc.delete();
   endtask

   task automatic clear_queues();
      q0.delete(); q1.delete(); q2.delete();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      clear_queues();
      tick(2);
      rst_n = 1'b1;
   endtask

   task automatic wait_log(input int n, input int budget, input string name);
      int b = 0;
      while (log_id.size() < n && b < budget) begin
         tick(1);
         b++;
      end
      chk(name, log_id.size(), n);
   endtask

   initial begin
      rst_n = 1'b0;
      out_ready = 1'b0;
      tick(3);
      chk("reset literal bot_rdy", int'(bot_rdy), 7);
      chk("reset literal out_valid", int'(out_valid), 0);
      rst_n = 1'b1;

      // Single report from bot 0: 1.0 / 0.5 in Q5.11.
      out_ready = 1'b1;
      clear_logs();
      send(0, 16'h0800, 16'h0400);
      wait_log(1, 20, "t1 report count");
      chk("t1 id", log_id[0], 0);
      chk("t1 px", log_px[0], 'h0800);
      chk("t1 py", log_py[0], 'h0400);
      chk("t1 latency", log_cyc[0] - acc_cyc[0], 2);
      chk("t1 slot free again", int'(bot_rdy[0]), 1);
      chk("t1 no frame", fd_cyc.size(), 0);

      // All three at once: transfers on accept+2/4/6, one frame pulse after id 2.
      do_reset();
      clear_logs();
      send(0, 16'h0100, 16'h0200);
      send(1, 16'h0300, 16'h0400);
      send(2, 16'h0500, 16'h0600);
      wait_log(3, 40, "t2 report count");
      tick(2);
      chk("t2 order 0", log_id[0], 0);
      chk("t2 order 1", log_id[1], 1);
      chk("t2 order 2", log_id[2], 2);
      chk("t2 px bot1", log_px[1], 'h0300);
      chk("t2 py bot2", log_py[2], 'h0600);
      chk("t2 cycle 0", log_cyc[0] - acc_cyc[0], 2);
      chk("t2 cycle 1", log_cyc[1] - acc_cyc[0], 4);
      chk("t2 cycle 2", log_cyc[2] - acc_cyc[0], 6);
      chk("t2 frame count", fd_cyc.size(), 1);
      chk("t2 frame cycle", fd_cyc[0] - acc_cyc[0], 6);

      // Consumer stall: report held, bot 1 refill blocked until the transfer.
      do_reset();
      clear_logs();
      out_ready = 1'b0;
      send(1, 16'h1234, 16'h5678);
      send(1, 16'h9abc, 16'hdef0);
      begin
         int b = 0;
         while (!out_valid && b < 20) begin tick(1); b++; end
      end
      chk("t3 presenting", int'(out_valid), 1);
      for (int k = 0; k < 5; k++) begin
         tick(1);
         chk("t3 hold valid", int'(out_valid), 1);
         chk("t3 hold id", int'(out_id), 1);
         chk("t3 hold px", int'(out_px), 'h1234);
         chk("t3 hold py", int'(out_py), 'h5678);
         chk("t3 slot blocked", int'(bot_rdy[1]), 0);
      end
      out_ready = 1'b1;
      wait_log(2, 30, "t3 report count");
      chk("t3 first px", log_px[0], 'h1234);
      chk("t3 second px", log_px[1], 'h9abc);
      chk("t3 second py", log_py[1], 'hdef0);
      chk("t3 refill spacing", log_cyc[1] - log_cyc[0], 3);

      // Bot 1 repeats; frame completes only once bots 0 and 2 have also reported.
      do_reset();
      clear_logs();
      send(1, 16'h0011, 16'h0012);
      send(1, 16'h0021, 16'h0022);
      send(1, 16'h0031, 16'h0032);
      send(2, 16'h0041, 16'h0042);
      wait_log(4, 60, "t4 report count");
      tick(2);
      chk("t4 order 0", log_id[0], 1);
      chk("t4 order 1", log_id[1], 2);
      chk("t4 order 2", log_id[2], 1);
      chk("t4 order 3", log_id[3], 1);
      chk("t4 third bot1 px", log_px[3], 'h0031);
      chk("t4 no early frame", fd_cyc.size(), 0);
      send(0, 16'h0051, 16'h0052);
      wait_log(5, 30, "t4 bot0 report");
      tick(2);
      chk("t4 last id", log_id[4], 0);
      chk("t4 frame count", fd_cyc.size(), 1);
      chk("t4 frame follows bot0", fd_cyc[0], log_cyc[4]);

      // Reset while presenting bot 1 with slots 1 and 2 full and bot 0 already seen.
      do_reset();
      clear_logs();
      send(0, 16'h0aaa, 16'h0bbb);
      wait_log(1, 20, "t5 bot0 report");
      out_ready = 1'b0;
      send(1, 16'h0ccc, 16'h0ddd);
      send(2, 16'h0eee, 16'h0fff);
      begin
         int b = 0;
         while (!(out_valid && bot_rdy == 3'b001) && b < 20) begin tick(1); b++; end
      end
      chk("t5 setup", int'(out_valid && bot_rdy == 3'b001 && out_id == 2'd1), 1);
      rst_n = 1'b0;
      clear_queues();
      #1;
      chk("t5 async out_valid", int'(out_valid), 0);
      chk("t5 async bot_rdy", int'(bot_rdy), 7);
      chk("t5 async frame_done", int'(frame_done), 0);
      tick(2);
      rst_n = 1'b1;
      out_ready = 1'b1;
      clear_logs();
      tick(5);
      chk("t5 no stale report", log_id.size(), 0);
      chk("t5 no frame after release", fd_cyc.size(), 0);
      send(1, 16'h0101, 16'h0102);
      send(2, 16'h0201, 16'h0202);
      wait_log(2, 30, "t5 post reset reports");
      tick(3);
      chk("t5 seen cleared", fd_cyc.size(), 0);
      chk("t5 post id 0", log_id[0], 1);
      chk("t5 post id 1", log_id[1], 2);

      // Bot 2 silent while bots 0 and 1 report every 10 cycles.
      do_reset();
      clear_logs();
      for (int t = 1; t <= 40; t++) begin
         if (t % 10 == 1) begin
            send(0, 16'(t), 16'h0001);
            send(1, 16'(t), 16'h0002);
         end
         tick(1);
         if (t == 19) chk("t6 stale2 before limit", int'(stale[2]), 0);
         if (t == 20) begin
`ifdef BOT_STALE_TIMEOUT_EN
            chk("t6 stale2 at limit", int'(stale[2]), 1);
`else
            chk("t6 stale2 at limit", int'(stale[2]), 0);
`endif
            chk("t6 active bots fresh", int'(stale[1:0]), 0);
         end
      end
      chk("t6 reports", log_id.size(), 8);
      send(2, 16'h0777, 16'h0888);
      wait_log(9, 30, "t6 bot2 report");
      tick(1);
      chk("t6 bot2 id", log_id[8], 2);
      chk("t6 stale cleared", int'(stale), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
